// File: rtl/filter_logic_fx.sv
// Fixed-point pair filter: 4-stage r^2 pipeline, cutoff test, FWFT output FIFO.
// Backpressure leaves room for every pair already in flight.
module filter_logic_fx #(
    parameter int          DATA_WIDTH   = 16,
    parameter int          TAG_WIDTH    = 8,
    parameter int          DEPTH        = 16,
    parameter int          ADDR_WIDTH   = 4,
    parameter int unsigned CUTOFF_2     = 144,
    parameter bit          EXCLUDE_SELF = 1'b1,
    localparam int         DW           = DATA_WIDTH + 1,
    localparam int         RW           = 2 * DATA_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    input  logic [DATA_WIDTH-1:0] refx,
    input  logic [DATA_WIDTH-1:0] refy,
    input  logic [DATA_WIDTH-1:0] refz,
    input  logic [DATA_WIDTH-1:0] neighborx,
    input  logic [DATA_WIDTH-1:0] neighbory,
    input  logic [DATA_WIDTH-1:0] neighborz,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    input  logic                  stat_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RW-1:0]         r2,
    output logic [DW-1:0]         dx,
    output logic [DW-1:0]         dy,
    output logic [DW-1:0]         dz,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  back_pressure,
    output logic                  overflow,
    output logic [31:0]           pair_in_cnt,
    output logic [31:0]           pair_pass_cnt
);

    localparam int SW = 2 * DW;
    localparam int EW = RW + 3 * DW + TAG_WIDTH;
    localparam logic [RW-1:0] CUT = RW'(CUTOFF_2);
    localparam logic [ADDR_WIDTH:0] BP_LVL = (ADDR_WIDTH + 1)'(DEPTH - 5);
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

    logic                 v1, v2, v3, v4, wv;
    logic [DW-1:0]        dx1, dy1, dz1, dx2, dy2, dz2;
    logic [DW-1:0]        dx3, dy3, dz3, dx4, dy4, dz4;
    logic [TAG_WIDTH-1:0] t1, t2, t3, t4;
    logic [SW-1:0]        sx2, sy2, sz2, sz3;
    logic [SW:0]          p3;
    logic [RW-1:0]        r2_4;
    logic                 pass4;
    logic [EW-1:0]        wdata;

    logic [EW-1:0]         mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full, rd_en, do_wr;
    logic [EW-1:0]         head;

    assign pass4 = v4 && (r2_4 < CUT) && !(EXCLUDE_SELF && (r2_4 == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
            wv <= 1'b0;
        end else begin
            v1 <= input_valid;
            v2 <= v1;
            v3 <= v2;
            v4 <= v3;
            wv <= pass4;
        end
    end

    // Data path carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        dx1 <= DW'($signed(refx)) - DW'($signed(neighborx));
        dy1 <= DW'($signed(refy)) - DW'($signed(neighbory));
        dz1 <= DW'($signed(refz)) - DW'($signed(neighborz));
        t1  <= tag_in;
        sx2 <= SW'($signed(dx1)) * SW'($signed(dx1));
        sy2 <= SW'($signed(dy1)) * SW'($signed(dy1));
        sz2 <= SW'($signed(dz1)) * SW'($signed(dz1));
        dx2 <= dx1;
        dy2 <= dy1;
        dz2 <= dz1;
        t2  <= t1;
        p3  <= {1'b0, sx2} + {1'b0, sy2};
        sz3 <= sz2;
        dx3 <= dx2;
        dy3 <= dy2;
        dz3 <= dz2;
        t3  <= t2;
        r2_4 <= RW'(p3) + RW'(sz3);
        dx4 <= dx3;
        dy4 <= dy3;
        dz4 <= dz3;
        t4  <= t3;
        wdata <= {r2_4, dz4, dy4, dx4, t4};
    end

    assign out_valid = (count != '0);
    assign full      = (count == FULL_LVL);
    assign rd_en     = out_valid && out_ready;
    assign do_wr     = wv && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !rd_en)
                count <= count + ONE;
            else if (rd_en && !do_wr)
                count <= count - ONE;
            if (wv && full && !rd_en)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_in_cnt   <= '0;
            pair_pass_cnt <= '0;
        end else if (stat_clear) begin
            pair_in_cnt   <= '0;
            pair_pass_cnt <= '0;
        end else begin
            if (input_valid && pair_in_cnt != '1)
                pair_in_cnt <= pair_in_cnt + 32'd1;
            if (do_wr && pair_pass_cnt != '1)
                pair_pass_cnt <= pair_pass_cnt + 32'd1;
        end
    end

    // Head is forced to zero when empty so stale memory never shows.
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {r2, dz, dy, dx, tag_out} = head;
    assign usedw = count;
    assign back_pressure = (count >= BP_LVL);

endmodule

// File: tb/tb_filter_logic_fx.sv
// Directed bench for filter_logic_fx: default instance plus one with
// self pairs allowed.
module tb_filter_logic_fx;

    localparam int DATA_WIDTH = 16;
    localparam int TAG_WIDTH  = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int DW         = DATA_WIDTH + 1;
    localparam int RW         = 2 * DATA_WIDTH + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic input_valid = 1'b0;
    logic [DATA_WIDTH-1:0] refx = '0, refy = '0, refz = '0;
    logic [DATA_WIDTH-1:0] neighborx = '0, neighbory = '0, neighborz = '0;
    logic [TAG_WIDTH-1:0] tag_in = '0;
    logic stat_clear = 1'b0;
    logic out_ready = 1'b0;

    logic out_valid, back_pressure, overflow;
    logic [RW-1:0] r2;
    logic [DW-1:0] dx, dy, dz;
    logic [TAG_WIDTH-1:0] tag_out;
    logic [ADDR_WIDTH:0] usedw;
    logic [31:0] pair_in_cnt, pair_pass_cnt;

    logic out_valid0, back_pressure0, overflow0;
    logic [RW-1:0] r2_0;
    logic [DW-1:0] dx0, dy0, dz0;
    logic [TAG_WIDTH-1:0] tag_out0;
    logic [ADDR_WIDTH:0] usedw0;
    logic [31:0] pair_in_cnt0, pair_pass_cnt0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    filter_logic_fx dut (
        .clk(clk), .rst(rst), .input_valid(input_valid),
        .refx(refx), .refy(refy), .refz(refz),
        .neighborx(neighborx), .neighbory(neighbory), .neighborz(neighborz),
        .tag_in(tag_in), .stat_clear(stat_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .r2(r2), .dx(dx), .dy(dy), .dz(dz), .tag_out(tag_out),
        .usedw(usedw), .back_pressure(back_pressure), .overflow(overflow),
        .pair_in_cnt(pair_in_cnt), .pair_pass_cnt(pair_pass_cnt)
    );

    filter_logic_fx #(.EXCLUDE_SELF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .input_valid(input_valid),
        .refx(refx), .refy(refy), .refz(refz),
        .neighborx(neighborx), .neighbory(neighbory), .neighborz(neighborz),
        .tag_in(tag_in), .stat_clear(stat_clear),
        .out_valid(out_valid0), .out_ready(out_ready),
        .r2(r2_0), .dx(dx0), .dy(dy0), .dz(dz0), .tag_out(tag_out0),
        .usedw(usedw0), .back_pressure(back_pressure0), .overflow(overflow0),
        .pair_in_cnt(pair_in_cnt0), .pair_pass_cnt(pair_pass_cnt0)
    );

    task automatic send(input int rx, input int ry, input int rz,
                        input int nx, input int ny, input int nz,
                        input int t);
        refx = 16'(rx); refy = 16'(ry); refz = 16'(rz);
        neighborx = 16'(nx); neighbory = 16'(ny); neighborz = 16'(nz);
        tag_in = 8'(t);
        input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic clear_stats();
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || usedw !== 5'd0 || back_pressure !== 1'b0 ||
            overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b usedw=%0d bp=%b ovf=%b, want 0 0 0 0",
                     out_valid, usedw, back_pressure, overflow);
        end
        n_checks++;
        if (pair_in_cnt !== 32'd0 || pair_pass_cnt !== 32'd0 || r2 !== '0 ||
            dx !== '0 || tag_out !== '0) begin
            n_fail++;
            $display("FAIL reset_data: in=%0d pass=%0d r2=%0d dx=%h tag=%0d, want zeros",
                     pair_in_cnt, pair_pass_cnt, r2, dx, tag_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send(0, 0, 0, 3, 4, 0, 7);
        idle(4);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid=%b after 4 edges, want 0", out_valid);
        end
        idle(1);
        n_checks++;
        if (out_valid !== 1'b1 || r2 !== 36'd25 || tag_out !== 8'd7) begin
            n_fail++;
            $display("FAIL basic_head: valid=%b r2=%0d tag=%0d, want 1 25 7",
                     out_valid, r2, tag_out);
        end
        n_checks++;
        if (dx !== 17'h1fffd || dy !== 17'h1fffc || dz !== 17'h00000) begin
            n_fail++;
            $display("FAIL basic_delta: dx=%h dy=%h dz=%h, want 1fffd 1fffc 00000",
                     dx, dy, dz);
        end
        n_checks++;
        if (pair_pass_cnt !== 32'd1 || pair_in_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_cnt: in=%0d pass=%0d, want 1 1",
                     pair_in_cnt, pair_pass_cnt);
        end
        pop_one();
        n_checks++;
        if (out_valid !== 1'b0 || usedw !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_pop: valid=%b usedw=%0d, want 0 0", out_valid, usedw);
        end
    endtask

    task automatic test_cutoff();
        clear_stats();
        n_checks++;
        if (pair_in_cnt !== 32'd0 || pair_pass_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stat_clear: in=%0d pass=%0d, want 0 0",
                     pair_in_cnt, pair_pass_cnt);
        end
        send(0, 0, 0, 12, 0, 0, 1);
        send(0, 0, 0, -11, -5, 1, 2);
        send(0, 0, 0, 11, 2, 2, 3);
        idle(5);
        n_checks++;
        if (usedw !== 5'd1 || r2 !== 36'd129 || tag_out !== 8'd3 || dx !== 17'h1fff5) begin
            n_fail++;
            $display("FAIL cutoff_head: usedw=%0d r2=%0d tag=%0d dx=%h, want 1 129 3 1fff5",
                     usedw, r2, tag_out, dx);
        end
        n_checks++;
        if (pair_in_cnt !== 32'd3 || pair_pass_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL cutoff_cnt: in=%0d pass=%0d, want 3 1",
                     pair_in_cnt, pair_pass_cnt);
        end
        pop_one();
    endtask

    task automatic test_self();
        clear_stats();
        send(5, 5, 5, 5, 5, 5, 3);
        idle(6);
        n_checks++;
        if (usedw !== 5'd0 || out_valid !== 1'b0 || pair_pass_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL self_excluded: usedw=%0d valid=%b pass=%0d, want 0 0 0",
                     usedw, out_valid, pair_pass_cnt);
        end
        n_checks++;
        if (usedw0 !== 5'd1 || out_valid0 !== 1'b1 || r2_0 !== 36'd0 ||
            tag_out0 !== 8'd3) begin
            n_fail++;
            $display("FAIL self_kept: usedw=%0d valid=%b r2=%0d tag=%0d, want 1 1 0 3",
                     usedw0, out_valid0, r2_0, tag_out0);
        end
        pop_one();
    endtask

    task automatic test_fill_overflow();
        int sent;
        int first_bp;
        int max_used;
        bit seen;
        sent = 0;
        first_bp = -1;
        max_used = 0;
        seen = 1'b0;
        clear_stats();
        for (int k = 0; k < 30; k++) begin
            if (back_pressure && !seen) begin
                seen = 1'b1;
                first_bp = int'(usedw);
            end
            if (int'(usedw) > max_used)
                max_used = int'(usedw);
            if (!back_pressure) begin
                neighborx = 16'd1; neighbory = '0; neighborz = '0;
                refx = '0; refy = '0; refz = '0;
                tag_in = 8'(sent);
                input_valid = 1'b1;
                sent++;
            end else begin
                input_valid = 1'b0;
            end
            @(negedge clk);
        end
        input_valid = 1'b0;
        n_checks++;
        if (first_bp != 11 || sent != 16) begin
            n_fail++;
            $display("FAIL fill_bp: bp first at usedw=%0d sent=%0d, want 11 16",
                     first_bp, sent);
        end
        n_checks++;
        if (max_used > 16 || usedw !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: max=%0d usedw=%0d ovf=%b, want <=16 16 0",
                     max_used, usedw, overflow);
        end
        send(0, 0, 0, 1, 0, 0, 99);
        idle(6);
        n_checks++;
        if (overflow !== 1'b1 || usedw !== 5'd16 || tag_out !== 8'd0 ||
            r2 !== 36'd1 || pair_pass_cnt !== 32'd16) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b usedw=%0d tag=%0d r2=%0d pass=%0d, want 1 16 0 1 16",
                     overflow, usedw, tag_out, r2, pair_pass_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || tag_out !== 8'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d: valid=%b tag=%0d, want 1 %0d",
                         i, out_valid, tag_out, i);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || usedw !== 5'd0) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%b usedw=%0d, want 0 0", out_valid, usedw);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(0, 0, 0, 0, 1, 0, 10);
        send(0, 0, 0, 0, 2, 0, 11);
        send(0, 0, 0, 0, 0, 3, 12);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || usedw !== 5'd1 || tag_out !== 8'(10 + i) ||
                r2 !== 36'((i + 1) * (i + 1))) begin
                n_fail++;
                $display("FAIL b2b_%0d: valid=%b usedw=%0d tag=%0d r2=%0d, want 1 1 %0d %0d",
                         i, out_valid, usedw, tag_out, r2, 10 + i, (i + 1) * (i + 1));
            end
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b0 || usedw !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_empty: valid=%b usedw=%0d, want 0 0", out_valid, usedw);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++)
            send(0, 0, 0, 2, 0, 0, 20 + i);
        idle(5);
        n_checks++;
        if (usedw !== 5'd4) begin
            n_fail++;
            $display("FAIL arst_pre: usedw=%0d, want 4", usedw);
        end
        for (int i = 0; i < 3; i++)
            send(0, 0, 0, 2, 0, 0, 30 + i);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || usedw !== 5'd0 || overflow !== 1'b0 ||
            pair_in_cnt !== 32'd0 || pair_pass_cnt !== 32'd0 || r2 !== '0 ||
            tag_out !== '0 || back_pressure !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_now: valid=%b usedw=%0d ovf=%b in=%0d pass=%0d r2=%0d tag=%0d, want zeros",
                     out_valid, usedw, overflow, pair_in_cnt, pair_pass_cnt, r2, tag_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        n_checks++;
        if (out_valid !== 1'b0 || usedw !== 5'd0 || pair_pass_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL arst_stale: valid=%b usedw=%0d pass=%0d, want 0 0 0",
                     out_valid, usedw, pair_pass_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cutoff();
        test_self();
        test_fill_overflow();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_logic_fx.md
# filter_logic_fx

Parametrised fixed-point successor to the range-limited pair filter. Computes dx/dy/dz and r² in a 4-stage integer pipeline and keeps only pairs with r² strictly below the cutoff, optionally excluding self pairs. Surviving pairs go into an internal first-word-fall-through FIFO with a valid/ready output, an exact-count backpressure flag, an overflow flag and pass/total statistics counters. The block sits between the cell-pair input generator and the filter arbiter of a force pipeline.

## Interface
- DATA_WIDTH, 16: signed two's-complement coordinate width.
- TAG_WIDTH, 8: neighbour-ID tag carried alongside each pair.
- DEPTH, 16: FIFO depth, power of two, ≥ 8.
- ADDR_WIDTH, 4: log2(DEPTH).
- CUTOFF_2, 144: unsigned r² threshold in coordinate-LSB² units; a pair passes only if r² < CUTOFF_2.
- EXCLUDE_SELF, 1: when 1, pairs with r² == 0 are dropped.
- Derived widths: DW = DATA_WIDTH+1 for the deltas; RW = 2*DATA_WIDTH+4 for r².
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- input_valid  in  1  pair valid this cycle.
- refx, refy, refz  in  DATA_WIDTH each  reference particle coordinates.
- neighborx, neighbory, neighborz  in  DATA_WIDTH each  neighbour particle coordinates.
- tag_in  in  TAG_WIDTH  neighbour ID.
- stat_clear  in  1  synchronous clear of both statistics counters.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes the head entry when out_valid && out_ready.
- r2  out  RW  r² of the head entry.
- dx, dy, dz  out  DW each  ref − neighbour of the head entry.
- tag_out  out  TAG_WIDTH  tag of the head entry.
- usedw  out  ADDR_WIDTH+1  FIFO occupancy, 0..DEPTH.
- back_pressure  out  1  source must not assert input_valid while high.
- overflow  out  1  sticky; set when a passing pair arrives while the FIFO is full and is not being read.
- pair_in_cnt, pair_pass_cnt  out  32 each  saturating counts of accepted inputs and of pairs written to the FIFO.

## Operation
- S1: dx = ref − neighbour (sign-extended to DW), same for y and z; tag and valid are registered.
- S2: each delta is squared into a 2*DW-bit unsigned value.
- S3: p = dx² + dy², and dz² is delayed one stage.
- S4: r² = p + dz² (RW bits, cannot overflow).
- Write stage: the pass condition is valid && r² < CUTOFF_2 && !(EXCLUDE_SELF && r² == 0). A passing pair writes {r2, dz, dy, dx, tag} into the FIFO on the next edge.
- FIFO: circular buffer with ADDR_WIDTH-bit pointers that wrap modulo DEPTH, and an ADDR_WIDTH+1-bit count. The head is driven combinationally from memory; there is no write-to-read bypass.
- Read and write in the same cycle: both take effect and usedw is unchanged. This holds when full, and also when usedw==1.
- Write while full with no read: the data is dropped, overflow is set, and usedw stays DEPTH.
- back_pressure = (DEPTH − usedw) ≤ 5, which covers the 4 pipeline stages plus the write stage. It is combinational from usedw.
- pair_in_cnt increments on each input_valid. pair_pass_cnt increments on each successful FIFO write. Both hold at 0xFFFFFFFF.
- stat_clear has priority over increment. It does not clear overflow.
- rst clears the pipeline valids, pointers, count, overflow and counters. Pairs in flight are discarded.

## Timing
- Reset values: out_valid 0, usedw 0, back_pressure 0, overflow 0, counters 0, r2/dx/dy/dz/tag_out 0.
- Latency: input sampled at edge 0 → r² valid after edge 4 → FIFO write at edge 5 → out_valid high in the cycle after edge 5, if the FIFO was empty.
- Throughput: 1 pair per cycle in and 1 pair per cycle out.
- The pipeline never stalls. Backpressure is the only flow control upstream.
- A read at edge n shows the next entry, or out_valid=0, after edge n.

## Test plan
- Ref (0,0,0), neighbour (3,4,0), tag 7 → after 5 cycles: out_valid=1, r2=25, dx=−3, dy=−4, dz=0, tag_out=7; pair_pass_cnt=1.
- Neighbour (12,0,0), then (−11,−5,1) → first pair dropped (144 is not < 144); second passes with r2=147? No — 147 ≥ 144, so it is also dropped. Then neighbour (11,2,2) → r2=129, passes. Expect pair_in_cnt=3, pair_pass_cnt=1.
- Ref = neighbour = (5,5,5): with EXCLUDE_SELF=1 → nothing written. Same stimulus with EXCLUDE_SELF=0 → one entry with r2=0.
- DEPTH=16, out_ready=0, source streams passing pairs while obeying back_pressure → back_pressure rises when usedw=11; usedw peaks ≤16; overflow stays 0. Then out_ready=1 → 16 entries drain in order across the pointer wrap.
- Source ignores back_pressure with the FIFO full → overflow=1, usedw=16, and the head entry is unchanged.
- Assert rst asynchronously mid-stream with 3 pairs in flight and 4 in the FIFO → all outputs return to reset values immediately. After release, no stale entry appears.
